// File: rtl/mc_controller_pkg.sv
// Shared constants for the multi-cycle MIPS main controller: FSM state codes,
// opcode/funct codes, ALU operation codes, datapath mux selects and the
// decoded instruction-class payload passed from instr_decode to the FSM.
package mc_controller_pkg;

   localparam int unsigned STATE_W = 3;
   localparam int unsigned OP_W    = 6;
   localparam int unsigned ALU_W   = 3;
   localparam int unsigned SEL_W   = 2;
   localparam int unsigned NPC_W   = 3;

   // FSM state codes (also visible on the debug state port)
   localparam logic [STATE_W-1:0] FETCH  = 3'd0;
   localparam logic [STATE_W-1:0] DECODE = 3'd1;
   localparam logic [STATE_W-1:0] EXEC   = 3'd2;
   localparam logic [STATE_W-1:0] MEM    = 3'd3;
   localparam logic [STATE_W-1:0] WB     = 3'd4;

   // Opcodes (IR[31:26])
   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
   localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

   // Function codes (IR[5:0]) for opcode 0
   localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
   localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
   localparam logic [OP_W-1:0] FN_JR  = 6'b001000;
   localparam logic [OP_W-1:0] FN_NOP = 6'b000000;

   // ALU operations
   localparam logic [ALU_W-1:0] ALU_ADD = 3'd0;
   localparam logic [ALU_W-1:0] ALU_SUB = 3'd1;
   localparam logic [ALU_W-1:0] ALU_OR  = 3'd2;
   localparam logic [ALU_W-1:0] ALU_LUI = 3'd3;

   // GRF write-address select
   localparam logic [SEL_W-1:0] RD_RT = 2'd0;
   localparam logic [SEL_W-1:0] RD_RD = 2'd1;
   localparam logic [SEL_W-1:0] RD_RA = 2'd2;

   // GRF write-data select
   localparam logic [SEL_W-1:0] RS_ALU = 2'd0;
   localparam logic [SEL_W-1:0] RS_MEM = 2'd1;
   localparam logic [SEL_W-1:0] RS_PC4 = 2'd2;

   // Next-PC select
   localparam logic [NPC_W-1:0] NPC_PC4 = 3'd0;
   localparam logic [NPC_W-1:0] NPC_BEQ = 3'd1;
   localparam logic [NPC_W-1:0] NPC_J   = 3'd2;
   localparam logic [NPC_W-1:0] NPC_JR  = 3'd3;

   // One-hot instruction class; exactly one field is set for any opcode/funct
   typedef struct packed {
      logic add;
      logic sub;
      logic jr;
      logic nop;
      logic ori;
      logic lui;
      logic lw;
      logic sw;
      logic beq;
      logic jal;
      logic illegal;
   } instr_class_t;

endpackage

// File: rtl/mc_controller_instr_decode.sv
// Combinational instruction classifier.
// Ports:
//   opcode_i : IR[31:26]
//   funct_i  : IR[5:0]
//   cls_o    : one-hot instruction class (illegal set for anything unsupported)
module instr_decode
   import mc_controller_pkg::*;
(
   input  logic [OP_W-1:0] opcode_i,
   input  logic [OP_W-1:0] funct_i,
   output instr_class_t    cls_o
);

   // Opcode/funct to class; unknown encodings fall through to illegal
   always_comb begin
      cls_o = '0;
      case (opcode_i)
         OP_RTYPE: begin
            case (funct_i)
               FN_ADD:  cls_o.add     = 1'b1;
               FN_SUB:  cls_o.sub     = 1'b1;
               FN_JR:   cls_o.jr      = 1'b1;
               FN_NOP:  cls_o.nop     = 1'b1;
               default: cls_o.illegal = 1'b1;
            endcase
         end
         OP_ORI:  cls_o.ori     = 1'b1;
         OP_LUI:  cls_o.lui     = 1'b1;
         OP_LW:   cls_o.lw      = 1'b1;
         OP_SW:   cls_o.sw      = 1'b1;
         OP_BEQ:  cls_o.beq     = 1'b1;
         OP_JAL:  cls_o.jal     = 1'b1;
         default: cls_o.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle main controller for the shared MIPS datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB, drives all datapath enables and mux
// selects combinationally from the current state and IR fields, handshakes
// with instruction/data memory and counts retired instructions.
// Ports:
//   clk, reset (async, active-low)
//   opcode, funct, zero          : IR fields and ALU zero flag
//   imem_ready, dmem_ready       : memory handshakes
//   imem_req, dmem_req, dmem_we  : memory requests
//   ir_we, pc_we, reg_we         : datapath write enables
//   reg_dst, reg_src, alu_src, alu_ctrl, ext_op, npc_sel : datapath selects
//   illegal                      : one-cycle pulse on unsupported instruction
//   state                        : current FSM state (debug)
//   retired                      : retired-instruction count (wraps)
module mc_controller
   import mc_controller_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [OP_W-1:0]    opcode,
   input  logic [OP_W-1:0]    funct,
   input  logic               zero,
   input  logic               imem_ready,
   input  logic               dmem_ready,
   output logic               imem_req,
   output logic               dmem_req,
   output logic               dmem_we,
   output logic               ir_we,
   output logic               pc_we,
   output logic               reg_we,
   output logic [SEL_W-1:0]   reg_dst,
   output logic [SEL_W-1:0]   reg_src,
   output logic               alu_src,
   output logic [ALU_W-1:0]   alu_ctrl,
   output logic               ext_op,
   output logic [NPC_W-1:0]   npc_sel,
   output logic               illegal,
   output logic [STATE_W-1:0] state,
   output logic [CNT_W-1:0]   retired
);

   logic [STATE_W-1:0] state_q, state_d;
   logic [CNT_W-1:0]   retired_q;
   instr_class_t       cls;
   logic               ex_alu_src;
   logic [ALU_W-1:0]   ex_alu_ctrl;
   logic               ex_ext_op;

   instr_decode u_instr_decode (
      .opcode_i (opcode),
      .funct_i  (funct),
      .cls_o    (cls)
   );

   // ALU setup per instruction; held through EXEC, MEM and WB so the
   // address and result stay stable until they are consumed
   always_comb begin
      ex_alu_src  = 1'b0;
      ex_alu_ctrl = ALU_ADD;
      ex_ext_op   = 1'b0;
      if (cls.ori) begin
         ex_alu_src  = 1'b1;
         ex_alu_ctrl = ALU_OR;
      end else if (cls.lui) begin
         ex_alu_src  = 1'b1;
         ex_alu_ctrl = ALU_LUI;
      end else if (cls.lw || cls.sw) begin
         ex_alu_src  = 1'b1;
         ex_ext_op   = 1'b1;
      end else if (cls.sub || cls.beq) begin
         ex_alu_ctrl = ALU_SUB;
      end
   end

   // State register and retired counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= FETCH;
         retired_q <= '0;
      end else begin
         state_q <= state_d;
         if (pc_we) begin
            retired_q <= retired_q + CNT_W'(1);
         end
      end
   end

   // Next state and outputs; everything is forced low while reset is held so
   // a reset mid-instruction cancels any in-flight write immediately
   always_comb begin
      state_d  = state_q;
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      reg_we   = 1'b0;
      reg_dst  = RD_RT;
      reg_src  = RS_ALU;
      alu_src  = 1'b0;
      alu_ctrl = ALU_ADD;
      ext_op   = 1'b0;
      npc_sel  = NPC_PC4;
      illegal  = 1'b0;
      if (reset) begin
         case (state_q)
            FETCH: begin
               imem_req = 1'b1;
               if (imem_ready) begin
                  ir_we   = 1'b1;
                  state_d = DECODE;
               end
            end
            DECODE: begin
               if (cls.jal) begin
                  reg_we  = 1'b1;
                  reg_dst = RD_RA;
                  reg_src = RS_PC4;
                  pc_we   = 1'b1;
                  npc_sel = NPC_J;
                  state_d = FETCH;
               end else if (cls.jr) begin
                  pc_we   = 1'b1;
                  npc_sel = NPC_JR;
                  state_d = FETCH;
               end else if (cls.nop || cls.illegal) begin
                  pc_we   = 1'b1;
                  illegal = cls.illegal;
                  state_d = FETCH;
               end else begin
                  state_d = EXEC;
               end
            end
            EXEC: begin
               alu_src  = ex_alu_src;
               alu_ctrl = ex_alu_ctrl;
               ext_op   = ex_ext_op;
               if (cls.beq) begin
                  // NPC picks the branch target itself from zero
                  pc_we   = 1'b1;
                  npc_sel = NPC_BEQ;
                  state_d = FETCH;
               end else if (cls.lw || cls.sw) begin
                  state_d = MEM;
               end else begin
                  state_d = WB;
               end
            end
            MEM: begin
               alu_src  = ex_alu_src;
               alu_ctrl = ex_alu_ctrl;
               ext_op   = ex_ext_op;
               dmem_req = 1'b1;
               dmem_we  = cls.sw;
               if (dmem_ready) begin
                  if (cls.sw) begin
                     pc_we   = 1'b1;
                     state_d = FETCH;
                  end else begin
                     state_d = WB;
                  end
               end
            end
            WB: begin
               alu_src  = ex_alu_src;
               alu_ctrl = ex_alu_ctrl;
               ext_op   = ex_ext_op;
               reg_we   = 1'b1;
               reg_dst  = (cls.add || cls.sub) ? RD_RD : RD_RT;
               reg_src  = cls.lw ? RS_MEM : RS_ALU;
               pc_we    = 1'b1;
               state_d  = FETCH;
            end
            default: state_d = FETCH;
         endcase
      end
   end

   assign state   = state_q;
   assign retired = retired_q;

endmodule
